alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Handshaked execute unit that consumes the 4-bit `alu_ctrl` code produced by the ALU control decoder and the two operands, and returns a registered result plus zero flag to the EX/MEM boundary. Single-cycle codes (AND, OR, ADD, SUB, SLT) complete in one cycle. MUL runs as an iterative shift-add over `WIDTH` cycles. The valid/ready handshakes on both sides let the pipeline stall cleanly while a multiply is in flight.

## Interface
- `WIDTH`, default 32: operand/result width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit accepts the request this cycle.
- `alu_ctrl`  in  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL; any other code executes as ADD.
- `op_a`, `op_b`  in  WIDTH  operands; `op_a` is rs1 and `op_b` is rs2 or the immediate.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream consumes the result.
- `result`  out  WIDTH  operation result.
- `zero`  out  1  high when `result == 0`; used for BEQ.

## Operation
- A request is accepted on the edge where `in_valid && in_ready`. Operands and code are captured at that edge; later input changes are ignored.
- State machine, encoded in 2 bits:
  - IDLE → DONE on accept of a single-cycle op. The result is computed from the captured inputs and registered at that edge.
  - IDLE → BUSY on accept of MUL. Load accumulator = 0, multiplicand = `op_a`, multiplier = `op_b`, counter = 0.
  - BUSY, each cycle: if multiplier[0] is set, add multiplicand to accumulator. Then shift multiplicand left 1 and multiplier right 1 (logical), and increment the counter. When the counter reaches WIDTH−1 this cycle, go to DONE with `result` = the final accumulator.
  - DONE with `out_ready` high: if `in_valid` is also high, accept the new request, following the same IDLE transitions (back-to-back). Otherwise go to IDLE.
  - DONE with `out_ready` low: hold; `result` and `zero` stay stable.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`). It is low throughout BUSY.
- `out_valid` = (state == DONE).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare: result = {WIDTH−1 zeros, (op_a < op_b signed)}.
  - MUL returns the low WIDTH bits of the unsigned product; this equals the signed low half, per RISC-V MUL.
- `zero` is registered together with `result`, not derived combinationally from the live state.

## Timing
- On reset: state = IDLE, `out_valid` = 0, `in_ready` = 1, `result` = 0, `zero` = 1, and all MUL datapath registers = 0.
- Single-cycle op accepted at edge N: `out_valid` = 1 in the cycle after edge N.
- MUL accepted at edge N: BUSY for WIDTH cycles; `out_valid` = 1 after edge N+WIDTH.
- Throughput: one single-cycle op per clock while `out_ready` is held high.
- Reset asserted mid-MUL or in DONE: the operation is abandoned with no output, and the reset values apply immediately (asynchronously).
- `out_ready` high while `out_valid` is low: no effect.
- `in_valid` high while BUSY: not accepted. The requester holds the request until `in_ready`.
- MUL by 0, or with `op_b` = 1: still takes the full WIDTH cycles; there is no early termination.

## Structure
- Shared package `alu_pkg`:
  - localparams for the six `alu_ctrl` codes;
  - the state encoding (IDLE=00, BUSY=01, DONE=10).
  - The ALU control decoder imports the same code constants.
- One sub-module, `shift_add_mul`. It holds the accumulator, multiplicand and multiplier registers and a `$clog2(WIDTH)`-bit counter.
  - Inputs: start, a, b. Outputs: done (a one-cycle pulse), product.
  - `alu_exec_unit` owns the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset, then ADD 5+7 with `out_ready` = 1 → `result` = 12 and `zero` = 0 one cycle after accept; `in_ready` is high throughout.
- SUB 9−9, then SLT −1 < 1 (0xFFFFFFFF vs 1), issued back-to-back → `result` = 0 with `zero` = 1, then `result` = 1; no bubble between them.
- MUL 0x0000FFFF × 0x00010001 → `result` = 0xFFFFFFFF after exactly 33 cycles. `in_ready` stays low for the 32 BUSY cycles.
- Backpressure: AND 0xF0F0 & 0xFF00 with `out_ready` low for 5 cycles → `result` = 0xF000 is held stable, `in_ready` stays low, and a second request is accepted only on the cycle `out_ready` rises.
- Undefined code 4'b1111 with operands 3, 4 → `result` = 7 (ADD behaviour).
- Assert `rst_n` low 10 cycles into a MUL → `out_valid` = 0, `result` = 0, `zero` = 1 immediately. After release, a new ADD 1+1 returns 2 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execute-unit state encoding; the ALU control
// decoder draws its code constants from this same package.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles,
// returning the low WIDTH bits of the product.
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_sum;

    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        busy_d   = busy_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // The last step's sum is offered combinationally so the owner can register
    // it on the same edge that retires the final iteration.
    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_sum;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute unit: single-cycle AND/OR/ADD/SUB/SLT plus an iterative MUL,
// with result and zero flag registered toward the EX/MEM boundary.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       state_dbg_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_out;

    // Valid/ready: a transfer happens on a rising edge where valid && ready;
    // a requester holds valid and its payload until that edge, and the result
    // stays stable while out_valid is high and out_ready is low.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);

    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_out = op_a & op_b;
            ALU_OR:  alu_out = op_a | op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_out = op_a + op_b;
        endcase
    end

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        mul_start = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_product;
                end
            end
            default: begin
                if (accept) begin
                    if (alu_ctrl == ALU_MUL) begin
                        state_d   = ST_BUSY;
                        mul_start = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_out;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_ctrl = 4'b0000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic [1:0]   state_dbg;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model: cycles left on a multiply, whether a result is presented,
    // and the result it must be.
    int           m_left = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_ctrl    (alu_ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .state_dbg_o (state_dbg)
    );

    function automatic logic [W-1:0] model_op(input logic [3:0] c, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? W'(1) : '0;
            ALU_MUL: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return p[W-1:0];
            end
            default: return a + b;
        endcase
    endfunction

    function automatic bit m_in_ready();
        return (m_left == 0) && (!m_valid || out_ready);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid = v;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        drive(1'b1, c, a, b);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < W + 4) begin
            step();
            n++;
        end
        #2;
        check1("op completes within budget", out_valid, 1'b1);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_valid  <= 1'b0;
            m_result <= '0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid  <= 1'b1;
                m_result <= exp_q.pop_front();
            end
        end else if (in_valid && m_in_ready()) begin
            if (alu_ctrl == ALU_MUL) begin
                m_left  <= W;
                m_valid <= 1'b0;
                exp_q.push_back(model_op(alu_ctrl, op_a, op_b));
            end else begin
                m_valid  <= 1'b1;
                m_result <= model_op(alu_ctrl, op_a, op_b);
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                check1("model reset out_valid", out_valid, 1'b0);
                check1("model reset in_ready", in_ready, 1'b1);
                check("model reset result", result, '0);
                check1("model reset zero", zero, 1'b1);
            end else begin
                check1("model out_valid", out_valid, m_valid);
                check1("model in_ready", in_ready, m_in_ready());
                if (m_valid) begin
                    check("model result", result, m_result);
                    check1("model zero", zero, m_result == '0);
                end
            end
        end
    end

    logic [3:0]   t_c[8];
    logic [W-1:0] t_a[8];
    logic [W-1:0] t_b[8];
    logic [W-1:0] t_e[8];

    initial begin
        t_c = '{ALU_OR, ALU_SLT, ALU_SLT, ALU_SUB, ALU_ADD, ALU_MUL, ALU_MUL, ALU_MUL};
        t_a = '{32'h0F0F_0000, 32'h8000_0000, 32'h0000_0005, 32'h0000_0000,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
        t_b = '{32'h0000_00F0, 32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_0001,
                32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        t_e = '{32'h0F0F_00F0, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF,
                32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'hDEAD_BEEF};

        // Reset
        repeat (2) step();
        chk_en = 1'b1;
        #2;
        check1("reset out_valid", out_valid, 1'b0);
        check1("reset in_ready", in_ready, 1'b1);
        check("reset result", result, '0);
        check1("reset zero", zero, 1'b1);
        rst_n = 1'b1;

        // ADD 5 + 7
        step();
        drive(1'b1, ALU_ADD, 5, 7);
        step();
        in_valid = 1'b0;
        #2;
        check("add result", result, 12);
        check1("add zero", zero, 1'b0);
        check1("add out_valid", out_valid, 1'b1);
        check1("add in_ready", in_ready, 1'b1);

        // SUB 9 - 9 then SLT -1 < 1, back-to-back
        drive(1'b1, ALU_SUB, 9, 9);
        step();
        drive(1'b1, ALU_SLT, 32'hFFFF_FFFF, 1);
        #2;
        check("sub result", result, 0);
        check1("sub zero", zero, 1'b1);
        step();
        in_valid = 1'b0;
        #2;
        check("slt result", result, 1);
        check1("slt out_valid", out_valid, 1'b1);

        // MUL with a held request behind it (undefined code runs as ADD)
        drive(1'b1, ALU_MUL, 32'h0000_FFFF, 32'h0001_0001);
        step();
        drive(1'b1, 4'b1111, 3, 4);
        for (int i = 0; i < W; i++) begin
            #2;
            check1("mul in_ready while busy", in_ready, 1'b0);
            check1("mul out_valid while busy", out_valid, 1'b0);
            step();
        end
        #2;
        check1("mul out_valid", out_valid, 1'b1);
        check("mul result", result, 32'hFFFF_FFFF);
        check1("mul zero", zero, 1'b0);
        step();
        in_valid = 1'b0;
        #2;
        check("undefined code result", result, 7);

        // Backpressure on AND
        step();
        #2;
        check1("idle out_valid", out_valid, 1'b0);
        out_ready = 1'b0;
        drive(1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        drive(1'b1, ALU_SUB, 10, 3);
        repeat (5) begin
            #2;
            check("and held result", result, 32'h0000_F000);
            check1("and held in_ready", in_ready, 1'b0);
            check1("and held out_valid", out_valid, 1'b1);
            step();
        end
        out_ready = 1'b1;
        #2;
        check1("in_ready on out_ready rise", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        #2;
        check("second request result", result, 7);

        // Reset 10 cycles into a multiply
        drive(1'b1, ALU_MUL, 32'h0000_1234, 32'h0000_5678);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        check1("mid-mul reset out_valid", out_valid, 1'b0);
        check("mid-mul reset result", result, '0);
        check1("mid-mul reset zero", zero, 1'b1);
        check1("mid-mul reset in_ready", in_ready, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;
        drive(1'b1, ALU_ADD, 1, 1);
        step();
        in_valid = 1'b0;
        #2;
        check("post-reset add result", result, 2);
        check1("post-reset add out_valid", out_valid, 1'b1);

        // Boundary vectors
        for (int i = 0; i < 8; i++) begin
            step();
            run_op(t_c[i], t_a[i], t_b[i]);
            check("table result", result, t_e[i]);
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
